// File: rtl/dcache_req_arbiter_if.sv
// dcache_req_arbiter_if: AXI AR/AW address channels plus the merged request port.
// slave = arbiter side, master = AXI source / downstream pipeline side.
//   AR: arid_i, araddr_i, arlen_i, arvalid_i -> arready_o
//   AW: awid_i, awaddr_i, awlen_i, awvalid_i -> awready_o
//   REQ: req_valid_o, req_data_o {is_wr, len, id, addr} <- req_ready_i
interface dcache_req_arbiter_if #(
    parameter int ID_W   = 16,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 8
);
    localparam int DATA_W = 1 + LEN_W + ID_W + ADDR_W;

    logic [ID_W-1:0]   arid_i;
    logic [ADDR_W-1:0] araddr_i;
    logic [LEN_W-1:0]  arlen_i;
    logic              arvalid_i;
    logic              arready_o;

    logic [ID_W-1:0]   awid_i;
    logic [ADDR_W-1:0] awaddr_i;
    logic [LEN_W-1:0]  awlen_i;
    logic              awvalid_i;
    logic              awready_o;

    logic              req_valid_o;
    logic              req_ready_i;
    logic [DATA_W-1:0] req_data_o;

    modport slave (
        input  arid_i, araddr_i, arlen_i, arvalid_i,
        output arready_o,
        input  awid_i, awaddr_i, awlen_i, awvalid_i,
        output awready_o,
        output req_valid_o, req_data_o,
        input  req_ready_i
    );

    modport master (
        output arid_i, araddr_i, arlen_i, arvalid_i,
        input  arready_o,
        output awid_i, awaddr_i, awlen_i, awvalid_i,
        input  awready_o,
        input  req_valid_o, req_data_o,
        output req_ready_i
    );
endinterface

// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: merges AXI AR and AW into one ordered request stream.
// Ports: clk, rst (sync, active high), io (dcache_req_arbiter_if.slave).
//   Each channel has a one-entry holder; a registered output slot feeds
//   the lookup pipeline. Round-robin with streak cap and same-line ordering.
module dcache_req_arbiter #(
    parameter int ID_W       = 16,
    parameter int ADDR_W     = 64,
    parameter int LEN_W      = 8,
    parameter int LINE_OFF   = 6,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    dcache_req_arbiter_if.slave io
);
    localparam int DATA_W = 1 + LEN_W + ID_W + ADDR_W;
    localparam int STRK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_STREAK);

    // holding registers
    logic              r_ar_held;
    logic [ID_W-1:0]   r_ar_id;
    logic [ADDR_W-1:0] r_ar_addr;
    logic [LEN_W-1:0]  r_ar_len;

    logic              r_aw_held;
    logic [ID_W-1:0]   r_aw_id;
    logic [ADDR_W-1:0] r_aw_addr;
    logic [LEN_W-1:0]  r_aw_len;

    // ordering / fairness state
    logic              r_age_vld;
    logic              r_age_aw_old;
    logic              r_last_aw;
    logic [STRK_W-1:0] r_streak;

    // output slot
    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_data;

    logic              w_ar_rdy;
    logic              w_aw_rdy;
    logic              w_ar_fire;
    logic              w_aw_fire;
    logic              w_both;
    logic              w_same_line;
    logic              w_streak_max;
    logic              w_out_free;
    logic              w_gnt_ar;
    logic              w_gnt_aw;
    logic              w_load;
    logic              w_ar_nxt;
    logic              w_aw_nxt;
    logic [DATA_W-1:0] w_gnt_data;

    // Ready reflects only holder occupancy, never the incoming valid.
    assign w_ar_rdy  = ~r_ar_held & ~rst;
    assign w_aw_rdy  = ~r_aw_held & ~rst;
    assign w_ar_fire = io.arvalid_i & w_ar_rdy;
    assign w_aw_fire = io.awvalid_i & w_aw_rdy;

    assign io.arready_o   = w_ar_rdy;
    assign io.awready_o   = w_aw_rdy;
    assign io.req_valid_o = r_out_vld & ~rst;
    assign io.req_data_o  = rst ? '0 : r_out_data;

    assign w_both       = r_ar_held & r_aw_held;
    assign w_same_line  = r_ar_addr[ADDR_W-1:LINE_OFF]
                       == r_aw_addr[ADDR_W-1:LINE_OFF];
    assign w_streak_max = (r_streak == STRK_MAX);
    assign w_out_free   = ~r_out_vld | io.req_ready_i;

    always_comb begin
        w_gnt_ar = 1'b0;
        w_gnt_aw = 1'b0;
        if (r_ar_held && !r_aw_held) begin
            w_gnt_ar = 1'b1;
        end else if (r_aw_held && !r_ar_held) begin
            w_gnt_aw = 1'b1;
        end else if (w_both && w_same_line) begin
            // Same line: keep arrival order; a tie goes to the read.
            w_gnt_aw = r_age_vld & r_age_aw_old;
            w_gnt_ar = ~(r_age_vld & r_age_aw_old);
        end else if (w_both && w_streak_max) begin
            w_gnt_aw = ~r_last_aw;
            w_gnt_ar = r_last_aw;
        end else if (w_both) begin
            w_gnt_aw = ~r_last_aw;
            w_gnt_ar = r_last_aw;
        end
    end

    assign w_load = (w_gnt_ar | w_gnt_aw) & w_out_free;

    assign w_gnt_data = w_gnt_aw
        ? {1'b1, r_aw_len, r_aw_id, r_aw_addr}
        : {1'b0, r_ar_len, r_ar_id, r_ar_addr};

    // Occupancy after this edge, used to decide the age bit.
    assign w_ar_nxt = (r_ar_held & ~(w_load & w_gnt_ar)) | w_ar_fire;
    assign w_aw_nxt = (r_aw_held & ~(w_load & w_gnt_aw)) | w_aw_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar_held <= 1'b0;
            r_ar_id   <= '0;
            r_ar_addr <= '0;
            r_ar_len  <= '0;
        end else if (w_ar_fire) begin
            r_ar_held <= 1'b1;
            r_ar_id   <= io.arid_i;
            r_ar_addr <= io.araddr_i;
            r_ar_len  <= io.arlen_i;
        end else if (w_load && w_gnt_ar) begin
            r_ar_held <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_aw_id   <= '0;
            r_aw_addr <= '0;
            r_aw_len  <= '0;
        end else if (w_aw_fire) begin
            r_aw_held <= 1'b1;
            r_aw_id   <= io.awid_i;
            r_aw_addr <= io.awaddr_i;
            r_aw_len  <= io.awlen_i;
        end else if (w_load && w_gnt_aw) begin
            r_aw_held <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_age_vld    <= 1'b0;
            r_age_aw_old <= 1'b0;
        end else if (!(w_ar_nxt && w_aw_nxt)) begin
            r_age_vld    <= 1'b0;
        end else if (w_ar_fire && !w_aw_fire) begin
            r_age_vld    <= 1'b1;
            r_age_aw_old <= 1'b1;
        end else if (w_aw_fire && !w_ar_fire) begin
            r_age_vld    <= 1'b1;
            r_age_aw_old <= 1'b0;
        end else if (w_ar_fire && w_aw_fire) begin
            r_age_vld    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_aw <= 1'b1;
            r_streak  <= '0;
        end else if (w_load) begin
            r_last_aw <= w_gnt_aw;
            if (w_gnt_aw == r_last_aw) begin
                r_streak <= w_streak_max ? STRK_MAX : r_streak + 1'b1;
            end else begin
                r_streak <= STRK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else if (w_load) begin
            r_out_vld  <= 1'b1;
            r_out_data <= w_gnt_data;
        end else if (io.req_ready_i) begin
            r_out_vld  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// tb_dcache_req_arbiter: directed vector table, streak sequence and a
// randomized run checked against a queue-based request-order model.
module tb_dcache_req_arbiter;
    localparam int ID_W       = 16;
    localparam int ADDR_W     = 64;
    localparam int LEN_W      = 8;
    localparam int LINE_OFF   = 6;
    localparam int MAX_STREAK = 4;
    localparam int DATA_W     = 1 + LEN_W + ID_W + ADDR_W;
    localparam logic [LEN_W-1:0] AL = 8'd3;
    localparam logic [LEN_W-1:0] WL = 8'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_req_arbiter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus();

    dcache_req_arbiter #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .LINE_OFF(LINE_OFF), .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic              rst;
        logic              arv;
        logic [ADDR_W-1:0] ara;
        logic [ID_W-1:0]   arid;
        logic              awv;
        logic [ADDR_W-1:0] awa;
        logic [ID_W-1:0]   awid;
        logic              rdy;
        logic              e_arr;
        logic              e_awr;
        logic              e_v;
        logic [DATA_W-1:0] e_d;
    } vec_t;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        int                stamp;
    } req_t;

    vec_t tbl[26];

    req_t m_ar_q[$];
    req_t m_aw_q[$];
    logic m_out_v;
    logic [DATA_W-1:0] m_out_d;
    int m_last_wr;
    int m_cyc;

    function automatic logic [DATA_W-1:0] mk(input logic wr,
        input logic [LEN_W-1:0] len, input logic [ID_W-1:0] id,
        input logic [ADDR_W-1:0] a);
        return {wr, len, id, a};
    endfunction

    function automatic vec_t v(input logic r, input logic arv,
        input logic [ADDR_W-1:0] ara, input logic [ID_W-1:0] arid,
        input logic awv, input logic [ADDR_W-1:0] awa,
        input logic [ID_W-1:0] awid, input logic rdy,
        input logic earr, input logic eawr, input logic ev,
        input logic [DATA_W-1:0] ed);
        vec_t t;
        t.rst = r;  t.arv = arv; t.ara = ara; t.arid = arid;
        t.awv = awv; t.awa = awa; t.awid = awid; t.rdy = rdy;
        t.e_arr = earr; t.e_awr = eawr; t.e_v = ev; t.e_d = ed;
        return t;
    endfunction

    task automatic drive(input logic r, input logic arv,
        input logic [ADDR_W-1:0] ara, input logic [ID_W-1:0] arid,
        input logic [LEN_W-1:0] arl, input logic awv,
        input logic [ADDR_W-1:0] awa, input logic [ID_W-1:0] awid,
        input logic [LEN_W-1:0] awl, input logic rdy);
        rst             = r;
        bus.arvalid_i   = arv;
        bus.araddr_i    = ara;
        bus.arid_i      = arid;
        bus.arlen_i     = arl;
        bus.awvalid_i   = awv;
        bus.awaddr_i    = awa;
        bus.awid_i      = awid;
        bus.awlen_i     = awl;
        bus.req_ready_i = rdy;
    endtask

    task automatic check(input string name, input logic e_arr,
        input logic e_awr, input logic e_v, input logic [DATA_W-1:0] e_d);
        logic bad;
        n_tests++;
        bad = (bus.arready_o !== e_arr) || (bus.awready_o !== e_awr)
           || (bus.req_valid_o !== e_v)
           || ((e_v || rst) && (bus.req_data_o !== e_d));
        if (bad) begin
            n_fail++;
            $display("FAIL %s @%0t: got arr=%b awr=%b v=%b d=%h, want arr=%b awr=%b v=%b d=%h",
                name, $time, bus.arready_o, bus.awready_o, bus.req_valid_o,
                bus.req_data_o, e_arr, e_awr, e_v, e_d);
        end
    endtask

    // Request-order model: holders are queues of depth one, age is the
    // capture cycle, and fairness is plain alternation (the streak cap
    // and round-robin both pick the channel not granted last).
    task automatic model_step();
        req_t a;
        req_t w;
        int pick;
        bit ar_in;
        bit aw_in;
        if (rst) begin
            m_ar_q.delete();
            m_aw_q.delete();
            m_out_v   = 1'b0;
            m_out_d   = '0;
            m_last_wr = 1;
        end else begin
            ar_in = bus.arvalid_i && (m_ar_q.size() == 0);
            aw_in = bus.awvalid_i && (m_aw_q.size() == 0);
            pick = -1;
            if (m_ar_q.size() != 0 && m_aw_q.size() == 0) begin
                pick = 0;
            end else if (m_ar_q.size() == 0 && m_aw_q.size() != 0) begin
                pick = 1;
            end else if (m_ar_q.size() != 0) begin
                a = m_ar_q[0];
                w = m_aw_q[0];
                if ((a.addr >> LINE_OFF) == (w.addr >> LINE_OFF))
                    pick = (w.stamp < a.stamp) ? 1 : 0;
                else
                    pick = 1 - m_last_wr;
            end
            if (pick >= 0 && (!m_out_v || bus.req_ready_i)) begin
                if (pick == 0) begin
                    a = m_ar_q.pop_front();
                    m_out_d = {1'b0, a.len, a.id, a.addr};
                end else begin
                    w = m_aw_q.pop_front();
                    m_out_d = {1'b1, w.len, w.id, w.addr};
                end
                m_out_v   = 1'b1;
                m_last_wr = pick;
            end else if (bus.req_ready_i) begin
                m_out_v = 1'b0;
            end
            if (ar_in)
                m_ar_q.push_back('{bus.arid_i, bus.araddr_i, bus.arlen_i, m_cyc});
            if (aw_in)
                m_aw_q.push_back('{bus.awid_i, bus.awaddr_i, bus.awlen_i, m_cyc});
        end
        m_cyc++;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        logic [ADDR_W-1:0] x;
        x = (64'($urandom_range(0, 3)) << LINE_OFF) | 64'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0)
            x = x | 64'hFFFF_0000_0000_0000;
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, single read
        tbl[0]  = v(1, 1, 64'h1000, 16'h5, 0, 0, 0, 1, 0, 0, 0, '0);
        tbl[1]  = v(1, 1, 64'h1000, 16'h5, 0, 0, 0, 1, 0, 0, 0, '0);
        tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, '0);
        tbl[3]  = v(0, 1, 64'h1000, 16'h5, 0, 0, 0, 1, 0, 1, 0, '0);
        tbl[4]  = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1,
                    mk(0, AL, 16'h5, 64'h1000));
        // round-robin from reset: AR first
        tbl[5]  = v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, '0);
        tbl[6]  = v(0, 1, 64'h100, 16'h1, 1, 64'h200, 16'h2, 1, 0, 0, 0, '0);
        tbl[7]  = v(0, 1, 64'h140, 16'h3, 1, 64'h240, 16'h4, 1, 1, 0, 1,
                    mk(0, AL, 16'h1, 64'h100));
        tbl[8]  = v(0, 1, 64'h140, 16'h3, 1, 64'h240, 16'h4, 1, 0, 1, 1,
                    mk(1, WL, 16'h2, 64'h200));
        tbl[9]  = v(0, 1, 64'h180, 16'h5, 1, 64'h240, 16'h4, 1, 1, 0, 1,
                    mk(0, AL, 16'h3, 64'h140));
        tbl[10] = v(0, 1, 64'h180, 16'h5, 1, 64'h280, 16'h6, 1, 0, 1, 1,
                    mk(1, WL, 16'h4, 64'h240));
        // same-line hazard with last-grant = AW
        tbl[11] = v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, '0);
        tbl[12] = v(0, 0, 0, 0, 1, 64'h3000, 16'h8, 0, 1, 0, 0, '0);
        tbl[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,
                    mk(1, WL, 16'h8, 64'h3000));
        tbl[14] = v(0, 0, 0, 0, 1, 64'h2000, 16'h7, 0, 1, 0, 1,
                    mk(1, WL, 16'h8, 64'h3000));
        tbl[15] = v(0, 1, 64'h2008, 16'h9, 0, 0, 0, 0, 0, 0, 1,
                    mk(1, WL, 16'h8, 64'h3000));
        tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1,
                    mk(1, WL, 16'h7, 64'h2000));
        tbl[17] = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1,
                    mk(0, AL, 16'h9, 64'h2008));
        tbl[18] = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, '0);
        // backpressure then mid-reset
        tbl[19] = v(0, 1, 64'h4000, 16'hA, 1, 64'h5000, 16'hB, 0, 0, 0, 0, '0);
        tbl[20] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                    mk(1, WL, 16'hB, 64'h5000));
        tbl[21] = v(0, 0, 0, 0, 1, 64'h6000, 16'hC, 0, 0, 0, 1,
                    mk(1, WL, 16'hB, 64'h5000));
        tbl[22] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                    mk(1, WL, 16'hB, 64'h5000));
        tbl[23] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        tbl[24] = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, '0);
        tbl[25] = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, '0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].arv, tbl[i].ara, tbl[i].arid, AL,
                  tbl[i].awv, tbl[i].awa, tbl[i].awid, WL, tbl[i].rdy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].e_arr, tbl[i].e_awr,
                  tbl[i].e_v, tbl[i].e_d);
        end

        // streak: AW alone reaches MAX_STREAK, then AR gets in next
        drive(1, 0, 0, 0, AL, 0, 0, 0, WL, 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, AL, 1, 64'h1000, 16'h20, WL, 1);
            @(posedge clk);
            #1;
        end
        check("streak_aw4", 1, 1, 1, mk(1, WL, 16'h20, 64'h1000));
        drive(0, 1, 64'h40, 16'h30, AL, 1, 64'h1000, 16'h20, WL, 1);
        @(posedge clk);
        #1;
        check("streak_both_held", 0, 0, 0, '0);
        drive(0, 0, 0, 0, AL, 0, 0, 0, WL, 1);
        @(posedge clk);
        #1;
        check("streak_ar_wins", 1, 0, 1, mk(0, AL, 16'h30, 64'h40));
        @(posedge clk);
        #1;
        check("streak_aw_after", 1, 1, 1, mk(1, WL, 16'h20, 64'h1000));

        // randomized run against the model
        m_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            drive((i < 2) || ($urandom_range(0, 99) == 0),
                  $urandom_range(0, 3) != 0, rnd_addr(),
                  ID_W'($urandom), LEN_W'($urandom),
                  $urandom_range(0, 3) != 0, rnd_addr(),
                  ID_W'($urandom), LEN_W'($urandom),
                  $urandom_range(0, 3) != 0);
            @(posedge clk);
            model_step();
            #1;
            check("rand", !rst && (m_ar_q.size() == 0),
                  !rst && (m_aw_q.size() == 0),
                  !rst && m_out_v, rst ? '0 : m_out_d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
